hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard detection unit for the RV32I pipeline with branches resolved in ID. It combines the following into one stall/bubble decision for the IF/ID and ID/EX boundary:
- load-use detection
- branch-in-ID operand hazards
- an optional no-forwarding mode
- a register scoreboard for long-latency (multi-cycle) operations
- a programmable post-reset stall window

It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register index width; scoreboard holds 2**REG_ADDR_W bits.
FORWARDING, 1, 1 = EX/MEM forwarding exists; 0 = every RAW on EX/MEM stalls.
RST_STALL_CYCLES, 4, cycles of forced stall after reset release (0 = none; max 255).
CNT_W, 32, stall counter width.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_id_valid  in  1  ID holds a real instruction
i_id_rs1  in  REG_ADDR_W  ID source 1
i_id_rs2  in  REG_ADDR_W  ID source 2
i_id_uses_rs1  in  1  ID reads rs1
i_id_uses_rs2  in  1  ID reads rs2
i_id_rd  in  REG_ADDR_W  ID destination
i_id_is_branch  in  1  ID is branch or JALR (needs operands in ID)
i_id_is_long  in  1  ID is a long-latency op (writes rd via completion port)
i_ex_rd  in  REG_ADDR_W  EX destination
i_ex_reg_write  in  1  EX writes rd
i_ex_mem_read  in  1  EX is load
i_mem_rd  in  REG_ADDR_W  MEM destination
i_mem_reg_write  in  1  MEM writes rd
i_mem_mem_read  in  1  MEM is load
i_long_done  in  1  long op completed this cycle
i_long_done_rd  in  REG_ADDR_W  its destination
i_cnt_clr  in  1  synchronous stall-counter clear
o_stall_pc  out  1  hold PC
o_stall_if_id  out  1  hold IF/ID
o_bubble_id_ex  out  1  load NOP into ID/EX
o_rst_busy  out  1  post-reset window active
o_pending  out  2**REG_ADDR_W  scoreboard contents
o_stall_cycles  out  CNT_W  saturating stall count

Behaviour:

Reset (asynchronous, i_rst_n=0):
- rst_cnt=RST_STALL_CYCLES.
- pending=0.
- o_stall_cycles=0.
- Outputs while in reset: o_rst_busy=(RST_STALL_CYCLES!=0); stall outputs equal o_rst_busy.

Reset window:
- rst_cnt is 8 bits. It decrements each clock while nonzero.
- o_rst_busy=(rst_cnt!=0).
- The stall is therefore held for exactly RST_STALL_CYCLES rising edges after reset release.

Helper term:
- match(rd,we) = i_id_valid && we && rd!=0 && ((i_id_uses_rs1 && rd==i_id_rs1) || (i_id_uses_rs2 && rd==i_id_rs2)).

Hazard terms, all combinational:
- load_use = match(ex) && i_ex_mem_read.
- br_ex = i_id_is_branch && match(ex). The ALU result is not available to the ID comparator in time.
- br_mem = i_id_is_branch && match(mem) && i_mem_mem_read.
- raw_nf = (FORWARDING==0) && (match(ex) || match(mem)).
  - WB writes the register file first-half, so WB needs no stall.
- sb_raw = i_id_valid && ((i_id_uses_rs1 && pending[i_id_rs1]) || (i_id_uses_rs2 && pending[i_id_rs2])).
- sb_waw = i_id_valid && i_id_is_long && pending[i_id_rd].

Stall decision:
- stall = o_rst_busy | load_use | br_ex | br_mem | raw_nf | sb_raw | sb_waw.
- o_stall_pc = o_stall_if_id = o_bubble_id_ex = stall.
- The stall outputs are combinational with zero latency.

Scoreboard:
- Issue means i_id_valid && i_id_is_long && !stall && i_id_rd!=0. On issue, pending[i_id_rd] is set at the clock edge.
- i_long_done clears pending[i_long_done_rd].
- pending[0] is always 0; writes to index 0 are ignored.
- Same-index set and clear in one cycle: set wins.
- No same-cycle bypass. A consumer sees pending cleared one cycle after i_long_done.

Stall counter:
- Increments when stall && !o_rst_busy.
- Saturates at all-ones.
- i_cnt_clr has priority and clears to 0 even while stalling.

Test Plan:
1. Reset, RST_STALL_CYCLES=4 → stall outputs and o_rst_busy high for exactly 4 cycles after i_rst_n rises; o_stall_cycles stays 0.
2. EX: load x5 (mem_read=1, rd=5); ID: add x6,x5,x1 (uses_rs1) → stall=1 for one cycle. With rd=0, or uses_rs1=0 with rs1=5 → stall=0.
3. FORWARDING=1: EX: addi x7, ID: beq x7,x0 → stall=1. Non-branch ID with the same operands → stall=0. FORWARDING=0: MEM rd=7 with non-branch ID → stall=1.
4. Issue long op rd=9 → o_pending[9]=1. Consumer of x9 stalls until cycle i_long_done(rd=9)+1. A second long op to rd=9 (WAW) stalls likewise.
5. i_long_done rd=3 in the same cycle as issue rd=3 → pending[3]=1 (set wins). Issue with rd=0 → o_pending unchanged.
6. CNT_W=4: hold a hazard for 20 cycles → o_stall_cycles=15 (saturated). Then i_cnt_clr while stalling → 0. Mid-operation async reset → pending, counter and rst_cnt reinitialised immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit for an RV32I pipeline with branches resolved in ID: merges load-use,
// branch-operand, no-forwarding RAW, long-op scoreboard and post-reset hazards into one stall.
// Stall outputs are combinational (zero latency); scoreboard and counters update on i_clk.
module hazard_scoreboard #(
  parameter int REG_ADDR_W       = 5,
  parameter int FORWARDING       = 1,
  parameter int RST_STALL_CYCLES = 4,
  parameter int CNT_W            = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_id_valid,
  input  logic [REG_ADDR_W-1:0]    i_id_rs1,
  input  logic [REG_ADDR_W-1:0]    i_id_rs2,
  input  logic                     i_id_uses_rs1,
  input  logic                     i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0]    i_id_rd,
  input  logic                     i_id_is_branch,
  input  logic                     i_id_is_long,
  input  logic [REG_ADDR_W-1:0]    i_ex_rd,
  input  logic                     i_ex_reg_write,
  input  logic                     i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0]    i_mem_rd,
  input  logic                     i_mem_reg_write,
  input  logic                     i_mem_mem_read,
  input  logic                     i_long_done,
  input  logic [REG_ADDR_W-1:0]    i_long_done_rd,
  input  logic                     i_cnt_clr,
  output logic                     o_stall_pc,
  output logic                     o_stall_if_id,
  output logic                     o_bubble_id_ex,
  output logic                     o_rst_busy,
  output logic [2**REG_ADDR_W-1:0] o_pending,
  output logic [CNT_W-1:0]         o_stall_cycles
);

  localparam int          NREG     = 2**REG_ADDR_W;
  localparam logic [7:0]  RST_INIT = 8'(RST_STALL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic [NREG-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_match, mem_match;
  logic load_use, br_ex, br_mem, raw_nf, sb_raw, sb_waw;
  logic stall, issue;

  // ID reads a register that an older in-flight instruction is about to write
  assign ex_match  = i_id_valid && i_ex_reg_write && (i_ex_rd != '0) &&
                     ((i_id_uses_rs1 && (i_ex_rd == i_id_rs1)) ||
                      (i_id_uses_rs2 && (i_ex_rd == i_id_rs2)));
  assign mem_match = i_id_valid && i_mem_reg_write && (i_mem_rd != '0) &&
                     ((i_id_uses_rs1 && (i_mem_rd == i_id_rs1)) ||
                      (i_id_uses_rs2 && (i_mem_rd == i_id_rs2)));

  // The branch comparator sits in ID, so an EX result is always too late for it,
  // and a MEM load result is too late as well; WB writes first-half so never stalls.
  assign load_use = ex_match && i_ex_mem_read;
  assign br_ex    = i_id_is_branch && ex_match;
  assign br_mem   = i_id_is_branch && mem_match && i_mem_mem_read;
  assign raw_nf   = (FORWARDING == 0) && (ex_match || mem_match);
  assign sb_raw   = i_id_valid && ((i_id_uses_rs1 && pending_q[i_id_rs1]) ||
                                   (i_id_uses_rs2 && pending_q[i_id_rs2]));
  assign sb_waw   = i_id_valid && i_id_is_long && pending_q[i_id_rd];

  assign o_rst_busy = (rst_cnt_q != 8'd0);
  assign stall      = o_rst_busy | load_use | br_ex | br_mem | raw_nf | sb_raw | sb_waw;
  assign issue      = i_id_valid && i_id_is_long && !stall && (i_id_rd != '0);

  assign o_stall_pc     = stall;
  assign o_stall_if_id  = stall;
  assign o_bubble_id_ex = stall;
  assign o_pending      = pending_q;
  assign o_stall_cycles = cnt_q;

  // Next state: reset window countdown, scoreboard set/clear, saturating stall counter
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;

    if (rst_cnt_q != 8'd0) begin
      rst_cnt_d = rst_cnt_q - 8'd1;
    end

    // Clear first so a same-index issue in the same cycle wins
    if (i_long_done) begin
      pending_d[i_long_done_rd] = 1'b0;
    end
    if (issue) begin
      pending_d[i_id_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (stall && !o_rst_busy && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous reinitialisation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_cnt_q <= RST_INIT;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard: two instances (forwarding on/off, 4-bit counter)
// share stimulus; a reference model pushes expected outputs into queues that a negedge monitor checks.
// Inputs change #1 after posedge; outputs are compared at negedge.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       br;
    logic       lng;
    logic [4:0] ex_rd;
    logic       ex_we;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic       mem_ld;
    logic       done;
    logic [4:0] done_rd;
    logic       clr;
  } vec_t;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic [31:0] pend;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vec_t cur = '0;

  logic        st_pc[2], st_ifid[2], bub[2], busy[2];
  logic [31:0] pend_o[2];
  logic [3:0]  cnt_o[2];

  // Reference model state, one copy per instance (index 0 = forwarding, 1 = no forwarding)
  int rcnt;
  bit mpend[2][32];
  int mcnt[2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_scoreboard #(
      .REG_ADDR_W(5), .FORWARDING(g == 0 ? 1 : 0), .RST_STALL_CYCLES(4), .CNT_W(4)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_id_valid(cur.id_valid), .i_id_rs1(cur.rs1), .i_id_rs2(cur.rs2),
      .i_id_uses_rs1(cur.u1), .i_id_uses_rs2(cur.u2), .i_id_rd(cur.rd),
      .i_id_is_branch(cur.br), .i_id_is_long(cur.lng),
      .i_ex_rd(cur.ex_rd), .i_ex_reg_write(cur.ex_we), .i_ex_mem_read(cur.ex_ld),
      .i_mem_rd(cur.mem_rd), .i_mem_reg_write(cur.mem_we), .i_mem_mem_read(cur.mem_ld),
      .i_long_done(cur.done), .i_long_done_rd(cur.done_rd), .i_cnt_clr(cur.clr),
      .o_stall_pc(st_pc[g]), .o_stall_if_id(st_ifid[g]), .o_bubble_id_ex(bub[g]),
      .o_rst_busy(busy[g]), .o_pending(pend_o[g]), .o_stall_cycles(cnt_o[g])
    );
  end

  function automatic bit reads(vec_t v, logic [4:0] r);
    return (v.u1 && v.rs1 == r) || (v.u2 && v.rs2 == r);
  endfunction

  // Stall rule set written directly from the hazard descriptions
  function automatic bit model_stall(int k, vec_t v);
    bit fwd = (k == 0);
    bit ex_hit, mem_hit;
    if (rcnt > 0) return 1'b1;
    if (!v.id_valid) return 1'b0;
    ex_hit  = v.ex_we  && v.ex_rd  != 0 && reads(v, v.ex_rd);
    mem_hit = v.mem_we && v.mem_rd != 0 && reads(v, v.mem_rd);
    if (ex_hit && (v.ex_ld || v.br || !fwd)) return 1'b1;
    if (mem_hit && ((v.br && v.mem_ld) || !fwd)) return 1'b1;
    if ((v.u1 && mpend[k][v.rs1]) || (v.u2 && mpend[k][v.rs2])) return 1'b1;
    if (v.lng && mpend[k][v.rd]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t mk(int k);
    exp_t e;
    e.stall = model_stall(k, cur);
    e.busy  = (rcnt != 0);
    for (int i = 0; i < 32; i++) e.pend[i] = mpend[k][i];
    e.cnt = 4'(mcnt[k]);
    return e;
  endfunction

  task automatic model_reset();
    rcnt = 4;
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      for (int i = 0; i < 32; i++) mpend[k][i] = 1'b0;
    end
  endtask

  // Advance the model over one clock edge using the inputs held during the past cycle
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit s = model_stall(k, cur);
      if (cur.clr) mcnt[k] = 0;
      else if (s && rcnt == 0 && mcnt[k] < 15) mcnt[k]++;
      if (cur.done) mpend[k][cur.done_rd] = 1'b0;
      if (cur.id_valid && cur.lng && !s && cur.rd != 0) mpend[k][cur.rd] = 1'b1;
      mpend[k][0] = 1'b0;
    end
    if (rcnt > 0) rcnt--;
  endtask

  task automatic step(vec_t v, bit rst_val);
    bit was_run;
    @(posedge clk);
    was_run = rst_n;
    #1;
    if (was_run) model_edge();
    rst_n = rst_val;
    if (!rst_val) model_reset();
    cur = v;
    q0.push_back(mk(0));
    q1.push_back(mk(1));
  endtask

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s[dut%0d] t=%0t got=%h expected=%h", nm, k, $time, act, req);
    end
  endtask

  // Monitor: one presented output set per cycle per instance
  always @(negedge clk) begin
    if (q0.size() != 0 && q1.size() != 0) begin
      exp_t e[2];
      e[0] = q0.pop_front();
      e[1] = q1.pop_front();
      n_vec++;
      for (int k = 0; k < 2; k++) begin
        chk("stall_pc",     k, 32'(st_pc[k]),   32'(e[k].stall));
        chk("stall_if_id",  k, 32'(st_ifid[k]), 32'(e[k].stall));
        chk("bubble_id_ex", k, 32'(bub[k]),     32'(e[k].stall));
        chk("rst_busy",     k, 32'(busy[k]),    32'(e[k].busy));
        chk("pending",      k, pend_o[k],       e[k].pend);
        chk("stall_cycles", k, 32'(cnt_o[k]),   32'(e[k].cnt));
      end
    end
  end

  function automatic vec_t rnd_vec();
    vec_t v = '0;
    v.id_valid = ($urandom_range(0, 9) < 8);
    v.rs1 = 5'($urandom_range(0, 7));
    v.rs2 = 5'($urandom_range(0, 7));
    v.u1 = 1'($urandom_range(0, 1));
    v.u2 = 1'($urandom_range(0, 1));
    v.rd = 5'($urandom_range(0, 7));
    v.br = ($urandom_range(0, 4) == 0);
    v.lng = ($urandom_range(0, 5) == 0);
    v.ex_rd = 5'($urandom_range(0, 7));
    v.ex_we = ($urandom_range(0, 9) < 6);
    v.ex_ld = ($urandom_range(0, 2) == 0);
    v.mem_rd = 5'($urandom_range(0, 7));
    v.mem_we = ($urandom_range(0, 9) < 6);
    v.mem_ld = ($urandom_range(0, 2) == 0);
    v.done = ($urandom_range(0, 9) < 3);
    v.done_rd = 5'($urandom_range(0, 7));
    v.clr = ($urandom_range(0, 29) == 0);
    return v;
  endfunction

  initial begin
    vec_t v;
    model_reset();
    // Power-on reset, release, then idle: busy for exactly 4 cycles
    for (int i = 0; i < 3; i++) step('0, 1'b0);
    for (int i = 0; i < 8; i++) step('0, 1'b1);

    // Load-use on x5 and its non-hazard variants
    v = '0; v.id_valid = 1; v.ex_rd = 5; v.ex_we = 1; v.ex_ld = 1; v.rs1 = 5; v.u1 = 1; v.rd = 6;
    step(v, 1);
    v.ex_rd = 0; step(v, 1);
    v.ex_rd = 5; v.u1 = 0; step(v, 1);

    // Branch on EX ALU result; non-branch; MEM producer
    v = '0; v.id_valid = 1; v.ex_rd = 7; v.ex_we = 1; v.rs1 = 7; v.u1 = 1; v.u2 = 1; v.br = 1;
    step(v, 1);
    v.br = 0; step(v, 1);
    v = '0; v.id_valid = 1; v.mem_rd = 7; v.mem_we = 1; v.rs1 = 7; v.u1 = 1; step(v, 1);
    v.br = 1; v.mem_ld = 1; step(v, 1);

    // Long op to x9, consumer, completion, WAW
    v = '0; v.id_valid = 1; v.lng = 1; v.rd = 9; step(v, 1);
    v = '0; v.id_valid = 1; v.rs2 = 9; v.u2 = 1; step(v, 1); step(v, 1);
    v.done = 1; v.done_rd = 9; step(v, 1);
    v.done = 0; step(v, 1);
    v = '0; v.id_valid = 1; v.lng = 1; v.rd = 9; step(v, 1);
    step(v, 1);
    v.done = 1; v.done_rd = 9; step(v, 1);
    v = '0; step(v, 1);

    // Same-cycle set/clear on x3, issue to x0
    v = '0; v.id_valid = 1; v.lng = 1; v.rd = 3; v.done = 1; v.done_rd = 3; step(v, 1);
    v = '0; v.id_valid = 1; v.lng = 1; v.rd = 0; step(v, 1);
    v = '0; step(v, 1);

    // Saturate counter, clear while stalling, then async reset mid-run
    v = '0; v.id_valid = 1; v.ex_rd = 5; v.ex_we = 1; v.ex_ld = 1; v.rs1 = 5; v.u1 = 1;
    for (int i = 0; i < 20; i++) step(v, 1);
    v.clr = 1; step(v, 1);
    v.clr = 0; step(v, 1); step(v, 1);
    step(v, 0); step(v, 0);
    for (int i = 0; i < 6; i++) step(v, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(rnd_vec(), 1'b0);
        step(rnd_vec(), 1'b0);
      end else begin
        step(rnd_vec(), 1'b1);
      end
    end

    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_miss++;
      $display("FAIL queue_drain left=%0d expected=0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
